// File: rtl/board_renderer.sv
// Board pixel path: VGA scan -> cell colour, with a per-row line buffer
// filled from the shared RAM port during horizontal blanking.
module board_renderer #(
  parameter int X0        = 220,
  parameter int Y0        = 40,
  parameter int CELL      = 20,
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              active,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              grid_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [11:0]       rgb,
  output logic              underrun
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(CELL);
  localparam int NB = 1 << CW;

  localparam logic [10:0]   XL    = 11'(X0);
  localparam logic [10:0]   XR    = 11'(X0 + COLS * CELL);
  localparam logic [9:0]    YT    = 10'(Y0);
  localparam logic [9:0]    YB    = 10'(Y0 + ROWS * CELL);
  localparam logic [SW-1:0] CM1   = SW'(CELL - 1);
  localparam logic [CW-1:0] CLAST = CW'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_f_q, col_f_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NB-1:0]          valid_q, valid_d;
  logic [NB-1:0][3:0]     cell_q, cell_d;

  logic                   act_prev_q, act_prev_d;
  logic [RW-1:0]          row_q, row_d;
  logic [SW-1:0]          sub_y_q, sub_y_d;
  logic [SW-1:0]          sub_x_q, sub_x_d;
  logic [CW-1:0]          col_q, col_d;

  logic                   s1_act_q, s1_act_d;
  logic                   s1_inb_q, s1_inb_d;
  logic                   s1_grid_q, s1_grid_d;
  logic [CW-1:0]          s1_col_q, s1_col_d;
  logic                   s1_hs_q, s1_hs_d;
  logic                   s1_vs_q, s1_vs_d;

  logic [11:0]            rgb_q, rgb_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   und_q, und_d;

  logic [9:0]             ny;
  logic                   start;
  logic                   at_x0;
  logic [SW-1:0]          sx;
  logic [CW-1:0]          cc;
  logic                   inb;
  logic [3:0]             code;
  logic [11:0]            pal;
  logic [11:0]            colour;
  logic                   und_set;
  logic                   unused_rdata;

  assign unused_rdata = ^mem_rdata[DATA_W-1:4];

  // Row tracking runs once per line, at the falling edge of active.
  always_comb begin
    ny         = {1'b0, y} + 10'd1;
    start      = 1'b0;
    row_d      = row_q;
    sub_y_d    = sub_y_q;
    act_prev_d = pix_en ? active : act_prev_q;
    if (pix_en && act_prev_q && !active) begin
      if (ny == YT) begin
        row_d   = '0;
        sub_y_d = '0;
        start   = 1'b1;
      end else if (ny > YT && ny < YB) begin
        if (sub_y_q == CM1) begin
          sub_y_d = '0;
          row_d   = row_q + RW'(1);
          start   = 1'b1;
        end else begin
          sub_y_d = sub_y_q + SW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    col_f_d = col_f_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    cell_d  = cell_q;
    mem_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          valid_d = '0;
          col_f_d = '0;
          addr_d  = ADDR_W'(BASE_ADDR)
                  + ADDR_W'(row_d) * ADDR_W'(COLS);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        cell_d[col_f_q]  = mem_rdata[3:0];
        valid_d[col_f_q] = 1'b1;
        if (col_f_q == CLAST) begin
          state_d = S_IDLE;
        end else begin
          col_f_d = col_f_q + CW'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr = addr_q;

  // sx/cc are the position of the pixel currently on x.
  always_comb begin
    at_x0   = ({1'b0, x} == XL);
    sx      = at_x0 ? '0 : sub_x_q;
    cc      = at_x0 ? '0 : col_q;
    sub_x_d = sub_x_q;
    col_d   = col_q;
    if (pix_en) begin
      if (sx == CM1) begin
        sub_x_d = '0;
        col_d   = cc + CW'(1);
      end else begin
        sub_x_d = sx + SW'(1);
        col_d   = cc;
      end
    end
  end

  always_comb begin
    inb = ({1'b0, x} >= XL) && ({1'b0, x} < XR)
       && ({1'b0, y} >= YT) && ({1'b0, y} < YB)
       && active;
    s1_act_d  = s1_act_q;
    s1_inb_d  = s1_inb_q;
    s1_grid_d = s1_grid_q;
    s1_col_d  = s1_col_q;
    s1_hs_d   = s1_hs_q;
    s1_vs_d   = s1_vs_q;
    if (pix_en) begin
      s1_act_d  = active;
      s1_inb_d  = inb;
      s1_grid_d = inb && grid_en
               && (sx == '0 || sx == CM1
                   || sub_y_q == '0 || sub_y_q == CM1);
      s1_col_d  = cc;
      s1_hs_d   = hsync_i;
      s1_vs_d   = vsync_i;
    end
  end

  always_comb begin
    code = cell_q[s1_col_q];
    pal  = 12'h000;
    case (code[2:0])
      3'd0: pal = 12'h000;
      3'd1: pal = 12'h0FF;
      3'd2: pal = 12'hFF0;
      3'd3: pal = 12'h4F0;
      3'd4: pal = 12'hF00;
      3'd5: pal = 12'hA0F;
      3'd6: pal = 12'hE80;
      3'd7: pal = 12'h02F;
      default: pal = 12'h000;
    endcase
  end

  always_comb begin
    colour  = 12'h000;
    und_set = 1'b0;
    if (!s1_act_q) begin
      colour = 12'h000;
    end else if (s1_grid_q) begin
      colour = 12'hFFF;
    end else if (!s1_inb_q) begin
      colour = 12'h000;
    end else if (!valid_q[s1_col_q]) begin
      colour  = 12'h000;
      und_set = 1'b1;
    end else if (code[3]) begin
      colour = {1'b0, pal[11:9], 1'b0, pal[7:5], 1'b0, pal[3:1]};
    end else begin
      colour = pal;
    end
    rgb_d = pix_en ? colour  : rgb_q;
    hs_d  = pix_en ? s1_hs_q : hs_q;
    vs_d  = pix_en ? s1_vs_q : vs_q;
    und_d = und_q | (pix_en & und_set);
  end

  assign rgb      = rgb_q;
  assign hsync_o  = hs_q;
  assign vsync_o  = vs_q;
  assign underrun = und_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_f_q    <= '0;
      addr_q     <= '0;
      valid_q    <= '0;
      cell_q     <= '0;
      act_prev_q <= 1'b0;
      row_q      <= '0;
      sub_y_q    <= '0;
      sub_x_q    <= '0;
      col_q      <= '0;
      s1_act_q   <= 1'b0;
      s1_inb_q   <= 1'b0;
      s1_grid_q  <= 1'b0;
      s1_col_q   <= '0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      rgb_q      <= 12'h000;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_f_q    <= col_f_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      cell_q     <= cell_d;
      act_prev_q <= act_prev_d;
      row_q      <= row_d;
      sub_y_q    <= sub_y_d;
      sub_x_q    <= sub_x_d;
      col_q      <= col_d;
      s1_act_q   <= s1_act_d;
      s1_inb_q   <= s1_inb_d;
      s1_grid_q  <= s1_grid_d;
      s1_col_q   <= s1_col_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      und_q      <= und_d;
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: default board plus a small 4x3 board
// sharing the same scan inputs.
module tb_board_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic        hsync_i;
  logic        vsync_i;
  logic        grid_en;
  logic        gnt_block;

  logic        mem_req0, mem_gnt0, hs0, vs0, und0;
  logic [11:0] mem_addr0, rgb0;
  logic [31:0] rdata0;
  logic        mem_req1, mem_gnt1, hs1, vs1, und1;
  logic [11:0] mem_addr1, rgb1;
  logic [31:0] rdata1;

  logic [31:0] ram [0:4095];
  logic [11:0] cap0 [0:1023];
  logic [11:0] cap1 [0:1023];
  logic        caph [0:1023];
  logic        capv [0:1023];
  int          prev_x = 0;

  int          total = 0;
  int          bad = 0;

  logic        log_en = 1'b0;
  int          log_n = 0;
  logic [11:0] log_a [0:31];
  int          log_y [0:31];

  always #5 clock = ~clock;

  assign mem_gnt0 = ~gnt_block;
  assign mem_gnt1 = 1'b1;

  always @(posedge clock) begin
    rdata0 <= ram[mem_addr0];
    rdata1 <= ram[mem_addr1];
  end

  always @(posedge clock) begin
    if (log_en && mem_req1 && mem_gnt1 && log_n < 32) begin
      log_a[log_n] <= mem_addr1;
      log_y[log_n] <= int'(y);
      log_n        <= log_n + 1;
    end
  end

  board_renderer u0 (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .x(x), .y(y), .active(active),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .grid_en(grid_en),
    .mem_req(mem_req0), .mem_addr(mem_addr0),
    .mem_gnt(mem_gnt0), .mem_rdata(rdata0),
    .hsync_o(hs0), .vsync_o(vs0), .rgb(rgb0), .underrun(und0)
  );

  board_renderer #(
    .COLS(4), .ROWS(3), .CELL(8), .BASE_ADDR(100)
  ) u1 (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .x(x), .y(y), .active(active),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .grid_en(grid_en),
    .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_gnt(mem_gnt1), .mem_rdata(rdata1),
    .hsync_o(hs1), .vsync_o(vs1), .rgb(rgb1), .underrun(und1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel strobe; the sample after the edge belongs to the previous pixel.
  task automatic strobe(input int xx, input int yy, input logic act,
                        input logic hs, input logic vs);
    @(negedge clock);
    x       = 10'(xx);
    y       = 9'(yy);
    active  = act;
    hsync_i = hs;
    vsync_i = vs;
    pix_en  = 1'b1;
    @(posedge clock);
    #1;
    cap0[prev_x] = rgb0;
    cap1[prev_x] = rgb1;
    caph[prev_x] = hs0;
    capv[prev_x] = vs0;
    prev_x = xx;
    @(negedge clock);
    pix_en = 1'b0;
  endtask

  task automatic run_line(input int yy, input int xs, input int xe,
                          input int nb, input logic vs);
    for (int i = xs; i <= xe; i++) strobe(i, yy, 1'b1, 1'b1, vs);
    for (int i = 0; i < nb; i++)
      strobe(640 + i, yy, 1'b0, !(i >= 2 && i <= 5), 1'b1);
  endtask

  task automatic line(input int yy);
    run_line(yy, 216, 423, 40, 1'b1);
  endtask

  initial begin
    int nz;
    pix_en    = 1'b0;
    x         = '0;
    y         = '0;
    active    = 1'b0;
    hsync_i   = 1'b1;
    vsync_i   = 1'b1;
    grid_en   = 1'b0;
    gnt_block = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    ram[0]   = 32'h1;
    ram[2]   = 32'hF;
    ram[3]   = 32'h8;
    ram[11]  = 32'h4;
    ram[105] = 32'h2;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rgb", 32'(rgb0), 32'h000);
    chk("rst_hsync", 32'(hs0), 32'h1);
    chk("rst_vsync", 32'(vs0), 32'h1);
    chk("rst_req", 32'(mem_req0), 32'h0);
    chk("rst_addr", 32'(mem_addr0), 32'h0);
    chk("rst_underrun", 32'(und0), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    run_line(100, 96, 104, 8, 1'b0);
    chk("px_100_100", 32'(cap0[100]), 32'h000);
    chk("vsync_align", 32'(capv[100]), 32'h0);

    log_en = 1'b1;
    for (int yy = 39; yy <= 65; yy++) begin
      line(yy);
      if (yy == 45) begin
        chk("f1_225_45", 32'(cap0[225]), 32'h0FF);
        chk("f1_220_45_nogrid", 32'(cap0[220]), 32'h0FF);
        chk("f1_219_45_left", 32'(cap0[219]), 32'h000);
        chk("f1_265_45_dim", 32'(cap0[265]), 32'h017);
        chk("f1_285_45_code8", 32'(cap0[285]), 32'h000);
        chk("hsync_pre", 32'(caph[641]), 32'h1);
        chk("hsync_low", 32'(caph[642]), 32'h0);
      end
      if (yy == 50) chk("u1_231_50", 32'(cap1[231]), 32'hFF0);
    end
    chk("f1_245_65", 32'(cap0[245]), 32'hF00);
    chk("f1_225_65", 32'(cap0[225]), 32'h000);
    chk("u1_225_65_out", 32'(cap1[225]), 32'h000);
    chk("f1_underrun", 32'(und0), 32'h0);
    log_en = 1'b0;
    chk("u1_fetch_count", 32'(log_n), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("u1_fetch_addr", 32'(log_a[i]), 32'(100 + i));
      chk("u1_fetch_line", 32'(log_y[i]), 32'(39 + 8 * (i / 4)));
    end

    grid_en = 1'b1;
    for (int yy = 39; yy <= 50; yy++) begin
      line(yy);
      if (yy == 40) chk("g_225_40", 32'(cap0[225]), 32'hFFF);
      if (yy == 45) begin
        chk("g_220_45", 32'(cap0[220]), 32'hFFF);
        chk("g_239_45", 32'(cap0[239]), 32'hFFF);
        chk("g_219_45", 32'(cap0[219]), 32'h000);
      end
    end
    chk("g_230_50", 32'(cap0[230]), 32'h0FF);
    grid_en = 1'b0;

    gnt_block = 1'b1;
    line(39);
    line(40);
    nz = 0;
    for (int i = 220; i < 420; i++) if (cap0[i] !== 12'h000) nz++;
    chk("blk_line40_black", 32'(nz), 32'd0);
    chk("blk_req_held", 32'(mem_req0), 32'h1);
    chk("blk_addr_held", 32'(mem_addr0), 32'h0);
    chk("blk_underrun", 32'(und0), 32'h1);
    gnt_block = 1'b0;
    for (int yy = 41; yy <= 45; yy++) begin
      line(yy);
      if (yy == 42) chk("late_225_42", 32'(cap0[225]), 32'h0FF);
    end
    chk("late_265_45", 32'(cap0[265]), 32'h017);
    chk("late_fetch_done", 32'(mem_req0), 32'h0);

    strobe(423, 39, 1'b1, 1'b1, 1'b1);
    strobe(640, 39, 1'b0, 1'b1, 1'b1);
    chk("mid_req_started", 32'(mem_req0), 32'h1);
    repeat (5) @(posedge clock);
    #1;
    chk("mid_addr_wait", 32'(mem_addr0), 32'h2);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req0), 32'h0);
    chk("mid_rst_addr", 32'(mem_addr0), 32'h0);
    chk("mid_rst_rgb", 32'(rgb0), 32'h000);
    chk("mid_rst_hsync", 32'(hs0), 32'h1);
    chk("mid_rst_vsync", 32'(vs0), 32'h1);
    chk("mid_rst_underrun", 32'(und0), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int yy = 39; yy <= 65; yy++) begin
      line(yy);
      if (yy == 45) begin
        chk("r_225_45", 32'(cap0[225]), 32'h0FF);
        chk("r_265_45", 32'(cap0[265]), 32'h017);
      end
    end
    chk("r_245_65", 32'(cap0[245]), 32'hF00);
    chk("r_underrun", 32'(und0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
